// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed multiply/divide unit writing HI/LO
// One result bit per clock; start/done handshake lets the control FSM stall.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divby0
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     counter;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic                 sign_a, sign_b, op_r;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 div_zero;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_signed;
  logic [WIDTH-1:0]     quot_signed, rem_signed;

  // Magnitudes; the most negative value maps to its unsigned magnitude.
  always_comb begin
    mag_a    = a[WIDTH-1] ? -a : a;
    mag_b    = b[WIDTH-1] ? -b : b;
    div_zero = op && (b == '0);
  end

  // Shift-add step: acc upper half accumulates, lower half holds the multiplier.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // Restoring step: acc upper half is the remainder, lower half the dividend/quotient.
  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    if (div_shift >= {1'b0, opnd})
      div_next = {div_diff, acc[WIDTH-2:0], 1'b1};
    else
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    prod_signed = (sign_a ^ sign_b) ? -acc : acc;
    quot_signed = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_signed  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !div_zero) state_nx = RUN;
      RUN:     if (counter == CNT_W'(WIDTH-1)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      divby0  <= 1'b0;
      counter <= '0;
      acc     <= '0;
      opnd    <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      op_r    <= 1'b0;
    end else begin
      done   <= 1'b0;
      divby0 <= 1'b0;
      case (state)
        IDLE: begin
          if (start && div_zero) begin
            done   <= 1'b1;
            divby0 <= 1'b1;
          end else if (start) begin
            sign_a  <= a[WIDTH-1];
            sign_b  <= b[WIDTH-1];
            op_r    <= op;
            counter <= '0;
            opnd    <= op ? mag_b : mag_a;
            acc     <= {{WIDTH{1'b0}}, (op ? mag_a : mag_b)};
          end
        end
        RUN: begin
          counter <= counter + CNT_W'(1);
          acc     <= op_r ? div_next : mul_next;
        end
        FINISH: begin
          done <= 1'b1;
          if (op_r) begin
            hi <= rem_signed;
            lo <= quot_signed;
          end else begin
            hi <= prod_signed[2*WIDTH-1:WIDTH];
            lo <= prod_signed[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential signed multiply/divide unit downstream of the opcode decode/control logic.
- Executes MIPS mult (funct 0x18/24) and div (funct 0x1A/26), and the divm path.
- Writes the HI/LO register pair and returns the divide-by-zero flag to the control logic.
- Iterative: one result bit per clock, with a start/done handshake so the control FSM can stall.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation. Sampled only in IDLE.
- op  input  1  0 = signed multiply, 1 = signed divide. Sampled with start.
- a  input  WIDTH  rs operand (multiplicand / dividend). Sampled with start.
- b  input  WIDTH  rt operand (multiplier / divisor). Sampled with start.
- hi  output  WIDTH  mult: product[63:32]; div: remainder.
- lo  output  WIDTH  mult: product[31:0]; div: quotient.
- busy  output  1  high while an operation is in flight (RUN or FINISH).
- done  output  1  one-cycle pulse: result committed, or div-by-zero abort.
- divby0  output  1  one-cycle pulse, coincident with done, on divide with b == 0.

Behaviour:
- Reset (synchronous, dominates everything):
  - hi = 0, lo = 0, busy = 0, done = 0, divby0 = 0, state = IDLE, counter = 0.
  - Applies even mid-operation; the partial result is discarded.
- States: IDLE, RUN, FINISH.
- IDLE, start = 0: hold all state. done and divby0 are 0.
- IDLE, start = 1 on edge k, valid operation:
  - Latch |a|, |b|, sign(a), sign(b), op.
  - Clear the accumulator and set counter = 0.
  - Go to RUN; busy = 1 from edge k.
- IDLE, start = 1 on edge k, op = 1 and b == 0:
  - No RUN. Stay in IDLE.
  - done = 1 and divby0 = 1 for the single cycle after edge k.
  - hi and lo keep their previous values.
- RUN:
  - Exactly WIDTH iterations, edges k+1 .. k+WIDTH; counter increments each edge.
  - Multiply: unsigned shift-add on magnitudes into a 2*WIDTH accumulator, one multiplier bit per edge, LSB first.
  - Divide: unsigned restoring division on magnitudes, one quotient bit per edge, MSB first.
  - After the edge where counter reaches WIDTH-1, go to FINISH.
- FINISH (edge k+WIDTH+1):
  - Apply sign correction and commit hi/lo; done = 1 for that one cycle; busy falls.
  - Return to IDLE.
  - Total: result visible WIDTH+1 edges after the start edge (33 for WIDTH = 32).
- Sign rules:
  - Product is negated when sign(a) XOR sign(b).
  - Quotient is negated when sign(a) XOR sign(b) and truncates toward zero.
  - Remainder takes the sign of the dividend.
- Arithmetic is two's complement with wrap; no overflow flag.
  - 0x80000000 / -1 gives lo = 0x80000000, hi = 0.
  - |0x80000000| is handled as unsigned 0x80000000.
- start while busy: ignored, no queueing. Operands on a/b/op are don't-care while busy.
- start in the same cycle done is high: done is only high in IDLE or after FINISH→IDLE, so the new start is accepted normally.
- hi/lo change only on the FINISH edge or reset; they are never partially visible during RUN.

Test Plan:
- Multiply 7 × -3: start, op = 0, a = 0x00000007, b = 0xFFFFFFFD → after 33 edges hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. done pulses 1 cycle; busy high for 33 cycles.
- Multiply 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0x00000000.
- Divide -7 / 2: a = 0xFFFFFFF9, b = 0x00000002, op = 1 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- Divide 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0x00000000.
- Divide by zero, with hi/lo preloaded from a prior mult:
  - a = 5, b = 0, op = 1 → done = 1 and divby0 = 1 on the cycle right after the start edge.
  - busy stays 0; hi/lo unchanged.
- Control handshake:
  - Start mult 3 × 4, then pulse start with a = 9, b = 9 at RUN edge 10 → ignored; result is lo = 12.
  - Separate run: assert reset at RUN edge 15 → next cycle hi = lo = 0, busy = 0, done never pulses.
